// File: rtl/legv8_instr_encoder_pkg.sv
// legv8_enc_pkg: opcodes, op/state encodings and field positions for the LEGv8 D/CB-format encoder.
package legv8_enc_pkg;
  typedef enum logic [1:0] {OP_LDUR, OP_STUR, OP_CBZ, OP_RSVD} op_e;
  typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_EMIT} state_e;
  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_CHECK = ST_CHECK;
  localparam logic [1:0] S_EMIT  = ST_EMIT;
  localparam logic [10:0] OPC_LDUR = 11'h7C2;
  localparam logic [10:0] OPC_STUR = 11'h7C0;
  localparam logic [7:0]  OPC_CBZ  = 8'hB4;
  localparam int D_IMM_W    = 9;
  localparam int CB_IMM_W   = 19;
  localparam int D_OPC_LSB  = 21;
  localparam int D_IMM_LSB  = 12;
  localparam int CB_OPC_LSB = 24;
  localparam int CB_IMM_LSB = 5;
  localparam int RN_LSB     = 5;
endpackage

// File: rtl/legv8_instr_encoder_if.sv
// legv8_instr_encoder_if: request/result handshake bundle between a request source and the encoder.
interface legv8_instr_encoder_if #(parameter int AW = 6);
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [4:0]    in_rt;
  logic [4:0]    in_rn;
  logic [63:0]   in_imm;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_addr;
  logic          out_err;
  modport slave (
    input  in_valid, in_op, in_rt, in_rn, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_err
  );
  modport master (
    output in_valid, in_op, in_rt, in_rn, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_err
  );
endinterface

// File: rtl/legv8_instr_encoder_imm_fits.sv
// imm_fits: checks that a 64-bit signed immediate is representable in 9 or 19 bits.
module imm_fits
  import legv8_enc_pkg::*;
(
  input  logic [63:0] i_imm,
  input  logic        i_w19,
  output logic        o_fits
);
  logic w_unused;
  logic w_fit9;
  logic w_fit19;
  assign w_unused = ^i_imm[D_IMM_W-2:0];
  // representable iff every bit from the field's sign bit upward agrees
  assign w_fit9  = (&i_imm[63:D_IMM_W-1]) | ~(|i_imm[63:D_IMM_W-1]);
  assign w_fit19 = (&i_imm[63:CB_IMM_W-1]) | ~(|i_imm[63:CB_IMM_W-1]);
  assign o_fits  = i_w19 ? w_fit19 : w_fit9;
endmodule

// File: rtl/legv8_instr_encoder.sv
// legv8_instr_encoder: range-checks an immediate and packs LDUR/STUR/CBZ words with a preload address.
module legv8_instr_encoder
  import legv8_enc_pkg::*;
#(
  parameter int AW = 6,
  parameter int CW = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  legv8_instr_encoder_if.slave   bus,
  output logic [CW-1:0]          n_ok,
  output logic [CW-1:0]          n_err
);
  logic [1:0]    r_state;
  logic [1:0]    r_op;
  logic [4:0]    r_rt;
  logic [4:0]    r_rn;
  logic [63:0]   r_imm;
  logic [31:0]   r_instr;
  logic          r_err;
  logic [AW-1:0] r_addr;
  logic [CW-1:0] r_n_ok;
  logic [CW-1:0] r_n_err;
  logic          w_cb;
  logic          w_fits;
  logic          w_bad;
  logic          w_hs;
  logic [10:0]   w_dopc;
  logic [31:0]   w_dword;
  logic [31:0]   w_cbword;
  logic [31:0]   w_word;
  imm_fits u_fits (
    .i_imm  (r_imm),
    .i_w19  (w_cb),
    .o_fits (w_fits)
  );
  always_comb begin
    w_cb     = r_op == OP_CBZ;
    w_bad    = (r_op == OP_RSVD) | ~w_fits;
    w_dopc   = (r_op == OP_STUR) ? OPC_STUR : OPC_LDUR;
    w_dword  = (32'(w_dopc) << D_OPC_LSB) | (32'(r_imm[D_IMM_W-1:0]) << D_IMM_LSB)
             | (32'(r_rn) << RN_LSB) | 32'(r_rt);
    w_cbword = (32'(OPC_CBZ) << CB_OPC_LSB) | (32'(r_imm[CB_IMM_W-1:0]) << CB_IMM_LSB) | 32'(r_rt);
    w_word   = w_bad ? 32'h0 : w_cb ? w_cbword : w_dword;
    w_hs     = (r_state == S_EMIT) & bus.out_ready;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_op    <= 2'd0;
      r_rt    <= 5'd0;
      r_rn    <= 5'd0;
      r_imm   <= 64'd0;
      r_instr <= 32'd0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_n_ok  <= '0;
      r_n_err <= '0;
    end else begin
      if (r_state == S_IDLE && bus.in_valid) begin
        r_op    <= bus.in_op;
        r_rt    <= bus.in_rt;
        r_rn    <= bus.in_rn;
        r_imm   <= bus.in_imm;
        r_state <= S_CHECK;
      end
      if (r_state == S_CHECK) begin
        r_instr <= w_word;
        r_err   <= w_bad;
        r_state <= S_EMIT;
      end
      // rejected words never consume an address slot
      if (w_hs) begin
        r_state <= S_IDLE;
        if (!r_err) begin
          r_addr <= r_addr + AW'(1);
          if (!(&r_n_ok)) r_n_ok <= r_n_ok + CW'(1);
        end else if (!(&r_n_err)) begin
          r_n_err <= r_n_err + CW'(1);
        end
      end
    end
  end
  assign bus.in_ready  = r_state == S_IDLE;
  assign bus.out_valid = r_state == S_EMIT;
  assign bus.out_instr = r_instr;
  assign bus.out_err   = r_err;
  assign bus.out_addr  = r_addr;
  assign n_ok          = r_n_ok;
  assign n_err         = r_n_err;
endmodule

// File: tb/tb_legv8_instr_encoder.sv
// tb_legv8_instr_encoder: vector table, directed corner sequences and random requests against an arithmetic model.
module tb_legv8_instr_encoder;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [15:0] a_nok, a_nerr;
  logic [1:0]  b_nok, b_nerr;
  int n_cmp = 0;
  int n_bad = 0;
  int ok_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  legv8_instr_encoder_if #(.AW(6)) ia ();
  legv8_instr_encoder_if #(.AW(2)) ib ();

  // the small instance sees identical traffic to exercise wrap and saturation
  assign ib.in_valid  = ia.in_valid;
  assign ib.in_op     = ia.in_op;
  assign ib.in_rt     = ia.in_rt;
  assign ib.in_rn     = ia.in_rn;
  assign ib.in_imm    = ia.in_imm;
  assign ib.out_ready = ia.out_ready;

  legv8_instr_encoder #(.AW(6), .CW(16)) dut_a (.clk(clk), .reset(reset), .bus(ia.slave), .n_ok(a_nok), .n_err(a_nerr));
  legv8_instr_encoder #(.AW(2), .CW(2))  dut_b (.clk(clk), .reset(reset), .bus(ib.slave), .n_ok(b_nok), .n_err(b_nerr));

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  rt;
    logic [4:0]  rn;
    logic [63:0] imm;
    logic [31:0] exp_instr;
    logic        exp_err;
    int          stall;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return v > mx ? mx : v;
  endfunction

  function automatic logic [32:0] ref_enc(input logic [1:0] op, input logic [4:0] rt, input logic [4:0] rn, input longint s);
    longint w;
    bit ok;
    if (op == 2'd3) return 33'h1_0000_0000;
    if (op == 2'd2) begin
      ok = s >= -262144 && s <= 262143;
      w = 64'hB400_0000 + (s & 64'h7FFFF) * 32 + longint'(rt);
    end else begin
      ok = s >= -256 && s <= 255;
      w = (op == 2'd0 ? 64'h7C2 : 64'h7C0) * 2097152 + (s & 64'h1FF) * 4096 + longint'(rn) * 32 + longint'(rt);
    end
    return ok ? {1'b0, w[31:0]} : 33'h1_0000_0000;
  endfunction

  task automatic chk_reset_vals();
    chk("rst_in_ready", ia.in_ready, 1);
    chk("rst_out_valid", ia.out_valid, 0);
    chk("rst_out_instr", ia.out_instr, 0);
    chk("rst_out_err", ia.out_err, 0);
    chk("rst_out_addr", ia.out_addr, 0);
    chk("rst_n_ok", a_nok, 0);
    chk("rst_n_err", a_nerr, 0);
    chk("rst_b_n_err", b_nerr, 0);
  endtask

  task automatic send(input logic [1:0] op, input logic [4:0] rt, input logic [4:0] rn, input logic [63:0] imm);
    int t = 0;
    @(negedge clk);
    while (!ia.in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("idle_in_ready", ia.in_ready, 1);
    ia.in_valid = 1'b1;
    ia.in_op = op;
    ia.in_rt = rt;
    ia.in_rn = rn;
    ia.in_imm = imm;
    @(posedge clk);
    #1 ia.in_valid = 1'b0;
    ia.in_imm = {$urandom, $urandom};
  endtask

  task automatic finish_req(input logic [31:0] ew, input logic ee, input int stall);
    int lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!ia.out_valid) chk("check_in_ready", ia.in_ready, 0);
    end while (!ia.out_valid && lat < 10);
    chk("latency", lat, 2);
    chk("out_instr", ia.out_instr, ew);
    chk("out_err", ia.out_err, ee);
    chk("out_addr", ia.out_addr, ok_cnt % 64);
    chk("b_out_instr", ib.out_instr, ew);
    chk("b_out_addr", ib.out_addr, ok_cnt % 4);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("hold_valid", ia.out_valid, 1);
      chk("hold_instr", ia.out_instr, ew);
      chk("hold_addr", ia.out_addr, ok_cnt % 64);
      chk("hold_in_ready", ia.in_ready, 0);
      chk("hold_n_ok", a_nok, sat(ok_cnt, 65535));
    end
    ia.out_ready = 1'b1;
    @(posedge clk);
    #1 ia.out_ready = 1'b0;
    if (ee) err_cnt++;
    else ok_cnt++;
    @(negedge clk);
    chk("post_valid", ia.out_valid, 0);
    chk("post_in_ready", ia.in_ready, 1);
    chk("n_ok", a_nok, sat(ok_cnt, 65535));
    chk("n_err", a_nerr, sat(err_cnt, 65535));
    chk("b_n_ok", b_nok, sat(ok_cnt, 3));
    chk("b_n_err", b_nerr, sat(err_cnt, 3));
    chk("b_valid", ib.out_valid, 0);
    chk("b_err", ib.out_err, ee);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    #1 chk_reset_vals();
    ok_cnt = 0;
    err_cnt = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [32:0] r;
    logic [63:0] imm;
    tbl[0] = '{2'd0, 5'd1,  5'd2,  -64'sd8,      32'hF85F8041, 1'b0, 0};
    tbl[1] = '{2'd1, 5'd3,  5'd4,  64'd16,       32'hF8010083, 1'b0, 5};
    tbl[2] = '{2'd2, 5'd5,  5'd9,  -64'sd1,      32'hB4FFFFE5, 1'b0, 0};
    tbl[3] = '{2'd0, 5'd0,  5'd0,  64'd255,      32'hF84FF000, 1'b0, 1};
    tbl[4] = '{2'd0, 5'd7,  5'd8,  64'd256,      32'h0,        1'b1, 2};
    tbl[5] = '{2'd2, 5'd1,  5'd0,  -64'sd262145, 32'h0,        1'b1, 0};
    tbl[6] = '{2'd3, 5'd1,  5'd2,  64'd0,        32'h0,        1'b1, 0};
    tbl[7] = '{2'd2, 5'd0,  5'd0,  64'd262143,   32'hB47FFFE0, 1'b0, 0};
    tbl[8] = '{2'd1, 5'd31, 5'd31, -64'sd256,    32'hF81003FF, 1'b0, 0};
    tbl[9] = '{2'd0, 5'd2,  5'd3,  -64'sd257,    32'h0,        1'b1, 0};
    ia.in_valid = 1'b0;
    ia.in_op = 2'd0;
    ia.in_rt = 5'd0;
    ia.in_rn = 5'd0;
    ia.in_imm = 64'd0;
    ia.out_ready = 1'b0;
    #12;
    chk_reset_vals();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(tbl[i].op, tbl[i].rt, tbl[i].rn, tbl[i].imm);
      finish_req(tbl[i].exp_instr, tbl[i].exp_err, tbl[i].stall);
    end
    // out_ready held high while idle must not count anything
    @(negedge clk);
    ia.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    ia.out_ready = 1'b0;
    chk("idle_ready_n_ok", a_nok, sat(ok_cnt, 65535));
    chk("idle_ready_n_err", a_nerr, sat(err_cnt, 65535));
    send(2'd0, 5'd4, 5'd5, 64'd12);
    @(negedge clk);
    chk("in_check_valid", ia.out_valid, 0);
    pulse_reset();
    send(2'd1, 5'd4, 5'd5, 64'd12);
    repeat (2) @(negedge clk);
    chk("in_emit_valid", ia.out_valid, 1);
    pulse_reset();
    send(2'd0, 5'd1, 5'd2, -64'sd8);
    finish_req(32'hF85F8041, 1'b0, 0);
    for (int n = 0; n < 300; n++) begin
      logic [1:0] op;
      logic [4:0] rt, rn;
      int cat;
      op = 2'($urandom_range(0, 3));
      rt = 5'($urandom);
      rn = 5'($urandom);
      cat = $urandom_range(0, 3);
      if (cat == 0) imm = 64'(longint'($urandom_range(0, 600)) - 300);
      else if (cat == 1) imm = 64'(longint'($urandom_range(0, 8)) - 4 + (($urandom & 1) != 0 ? 262144 : -262144));
      else if (cat == 2) imm = {$urandom, $urandom};
      else imm = 64'(longint'($urandom_range(0, 524287)) - 262144);
      r = ref_enc(op, rt, rn, longint'(imm));
      send(op, rt, rn, imm);
      finish_req(r[31:0], r[32], $urandom_range(0, 2));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
